// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: 4-bit lookahead groups plus a second-level carry unit.
// Optional signed overflow output enabled by defining CLA_PIPE_OVF_EN.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PIPE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             g_out,
  output logic             p_out,
  output logic             ovf
);

  localparam int NG = int'(WIDTH / 4);

  if (WIDTH % 4 != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 in 4..64");
  end
  if (PIPE > 1) begin : g_bad_pipe
    $error("cla_pipe_adder: PIPE must be 0 or 1");
  end

  function automatic logic grp_and(input logic [NG-1:0] v, input int lo, input int hi);
    logic r;
    r = 1'b1;
    for (int i = 0; i < NG; i++) if (i >= lo && i <= hi) r &= v[i];
    return r;
  endfunction

  function automatic logic bit_and(input logic [2:0] v, input int lo, input int hi);
    logic r;
    r = 1'b1;
    for (int i = 0; i < 3; i++) if (i >= lo && i <= hi) r &= v[i];
    return r;
  endfunction

  // The whole pipeline advances together; reset forces acceptance-ready.
  logic w_en;
  assign w_en     = ~(out_valid & ~out_ready);
  assign in_ready = rst | w_en;

  // Stage 0: operand capture with B already conditionally inverted.
  logic             r_v0, r_c00;
  logic [WIDTH-1:0] r_a0, r_b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v0  <= 1'b0;
      r_a0  <= '0;
      r_b0  <= '0;
      r_c00 <= 1'b0;
    end else if (w_en) begin
      r_v0  <= in_valid;
      r_a0  <= a;
      r_b0  <= sub ? ~b : b;
      r_c00 <= sub | cin;
    end
  end

  // Stage 1: per-bit and per-group generate/propagate.
  logic [WIDTH-1:0] w_g1, w_p1, w_t1;
  logic [NG-1:0]    w_gg1, w_gp1;
  logic [3*NG-1:0]  w_gl1, w_tl1;

  assign w_g1 = r_a0 & r_b0;
  assign w_p1 = r_a0 ^ r_b0;
  assign w_t1 = r_a0 | r_b0;

  always_comb begin
    w_gg1 = '0;
    w_gp1 = '0;
    w_gl1 = '0;
    w_tl1 = '0;
    for (int k = 0; k < NG; k++) begin
      w_gg1[k] = w_g1[4*k+3] | (w_t1[4*k+3] & w_g1[4*k+2])
               | (w_t1[4*k+3] & w_t1[4*k+2] & w_g1[4*k+1])
               | (w_t1[4*k+3] & w_t1[4*k+2] & w_t1[4*k+1] & w_g1[4*k]);
      w_gp1[k] = &w_t1[4*k +: 4];
      // Only the low three bits of each group feed in-group carries.
      w_gl1[3*k +: 3] = w_g1[4*k +: 3];
      w_tl1[3*k +: 3] = w_t1[4*k +: 3];
    end
  end

  logic             w_v2, w_c02;
  logic [WIDTH-1:0] w_p2;
  logic [NG-1:0]    w_gg2, w_gp2;
  logic [3*NG-1:0]  w_gl2, w_tl2;

  if (PIPE == 1) begin : g_pipe
    logic             r_v1, r_c01;
    logic [WIDTH-1:0] r_p1;
    logic [NG-1:0]    r_gg1, r_gp1;
    logic [3*NG-1:0]  r_gl1, r_tl1;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v1  <= 1'b0;
        r_c01 <= 1'b0;
        r_p1  <= '0;
        r_gg1 <= '0;
        r_gp1 <= '0;
        r_gl1 <= '0;
        r_tl1 <= '0;
      end else if (w_en) begin
        r_v1  <= r_v0;
        r_c01 <= r_c00;
        r_p1  <= w_p1;
        r_gg1 <= w_gg1;
        r_gp1 <= w_gp1;
        r_gl1 <= w_gl1;
        r_tl1 <= w_tl1;
      end
    end

    assign w_v2  = r_v1;
    assign w_c02 = r_c01;
    assign w_p2  = r_p1;
    assign w_gg2 = r_gg1;
    assign w_gp2 = r_gp1;
    assign w_gl2 = r_gl1;
    assign w_tl2 = r_tl1;
  end else begin : g_nopipe
    assign w_v2  = r_v0;
    assign w_c02 = r_c00;
    assign w_p2  = w_p1;
    assign w_gg2 = w_gg1;
    assign w_gp2 = w_gp1;
    assign w_gl2 = w_gl1;
    assign w_tl2 = w_tl1;
  end

  // Stage 2: flattened sum-of-products for group carries, then in-group carries.
  logic [NG:0]      w_cg;
  logic [WIDTH-1:0] w_c, w_sum;
  logic             w_gall;

  always_comb begin
    w_cg    = '0;
    w_cg[0] = w_c02;
    for (int k = 0; k < NG; k++) begin
      w_cg[k+1] = w_c02 & grp_and(w_gp2, 0, k);
      for (int j = 0; j <= k; j++) begin
        w_cg[k+1] = w_cg[k+1] | (w_gg2[j] & grp_and(w_gp2, j + 1, k));
      end
    end
    w_c = '0;
    for (int k = 0; k < NG; k++) begin
      for (int m = 0; m < 4; m++) begin
        w_c[4*k+m] = w_cg[k] & bit_and(w_tl2[3*k +: 3], 0, m - 1);
        for (int j = 0; j < m; j++) begin
          w_c[4*k+m] = w_c[4*k+m] | (w_gl2[3*k+j] & bit_and(w_tl2[3*k +: 3], j + 1, m - 1));
        end
      end
    end
    w_gall = 1'b0;
    for (int j = 0; j < NG; j++) w_gall = w_gall | (w_gg2[j] & grp_and(w_gp2, j + 1, NG - 1));
  end

  assign w_sum = w_p2 ^ w_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      g_out     <= 1'b0;
      p_out     <= 1'b0;
    end else if (w_en) begin
      out_valid <= w_v2;
      sum       <= w_sum;
      cout      <= w_cg[NG];
      g_out     <= w_gall;
      p_out     <= &w_gp2;
    end
  end

`ifdef CLA_PIPE_OVF_EN
  // Signed overflow is the carry into the MSB differing from the carry out of it.
  always_ff @(posedge clk) begin
    if (rst)       ovf <= 1'b0;
    else if (w_en) ovf <= w_c[WIDTH-1] ^ w_cg[NG];
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: four width/pipe configurations run in parallel,
// each with directed beats, backpressure, mid-stream reset and random traffic.
module tb_cla_pipe_adder;

  localparam int NCFG = 4;

  typedef struct packed {
    logic [63:0] s;
    logic        c;
    logic        g;
    logic        p;
    logic        o;
  } exp_t;

  logic clk;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, want);
    end
  endtask

  task automatic mark_done();
    n_done++;
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int W = (gi == 2) ? 4 : (gi == 3) ? 64 : 16;
    localparam int P = gi % 2;

    logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready;
    logic         cout, g_out, p_out, ovf, rnd;
    logic [W-1:0] a, b, sum;
    exp_t         q[$];

    cla_pipe_adder #(.WIDTH(W), .PIPE(P)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .g_out    (g_out),
      .p_out    (p_out),
      .ovf      (ovf)
    );

    function automatic string nm(input string s);
      return $sformatf("cfg%0d_w%0d_p%0d_%s", gi, W, P, s);
    endfunction

    // Reference: plain wide arithmetic on A, B' and the effective carry-in.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input logic tc, input logic ts);
      logic [W-1:0] bp;
      logic [W:0]   full, gen;
      exp_t         e;
      bp   = ts ? ~tb : tb;
      full = {1'b0, ta} + {1'b0, bp} + {{W{1'b0}}, ts | tc};
      gen  = {1'b0, ta} + {1'b0, bp};
      e    = '0;
      e.s  = 64'(full[W-1:0]);
      e.c  = full[W];
      e.g  = gen[W];
      e.p  = &(ta | bp);
`ifdef CLA_PIPE_OVF_EN
      e.o  = (ta[W-1] == bp[W-1]) && (full[W-1] != ta[W-1]);
`endif
      return e;
    endfunction

    function automatic logic [W-1:0] rv();
      logic [63:0] x;
      x = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       return '0;
        1:       return '1;
        default: return x[W-1:0];
      endcase
    endfunction

    task automatic tick();
      @(posedge clk);
      #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts);
      a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (in_ready) break;
        tick();
      end
      if (in_ready) q.push_back(model(ta, tb, tc, ts));
      else chk(nm("in_ready_timeout"), 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
    endtask

    task automatic drain();
      for (int k = 0; k < 100 && q.size() != 0; k++) tick();
      chk(nm("drain_empty"), 64'(q.size()), 64'd0);
    endtask

    initial begin : mon
      exp_t         e;
      logic         pv, pr, prst;
      logic [W-1:0] ps;
      pv = 1'b0; pr = 1'b0; prst = 1'b1; ps = '0;
      forever begin
        @(negedge clk);
        if (pv && !pr && !prst) begin
          chk(nm("stall_valid_hold"), 64'(out_valid), 64'd1);
          chk(nm("stall_sum_hold"), 64'(sum), 64'(ps));
        end
        if (!rst && out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk(nm("unexpected_output"), 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            chk(nm("sum"), 64'(sum), e.s);
            chk(nm("cout"), 64'(cout), 64'(e.c));
            chk(nm("g_out"), 64'(g_out), 64'(e.g));
            chk(nm("p_out"), 64'(p_out), 64'(e.p));
            chk(nm("ovf"), 64'(ovf), 64'(e.o));
          end
        end
        pv = out_valid; pr = out_ready; prst = rst; ps = sum;
      end
    end

    initial begin : drv
      int           lat, idx;
      logic         fresh;
      logic [W-1:0] held;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1; rnd = 1'b0;
      @(negedge clk);
      chk(nm("in_ready_in_reset"), 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk(nm("rst_out_valid"), 64'(out_valid), 64'd0);
      chk(nm("rst_sum"), 64'(sum), 64'd0);
      chk(nm("rst_flags"), 64'({cout, g_out, p_out, ovf}), 64'd0);
      chk(nm("rst_in_ready"), 64'(in_ready), 64'd1);

      // Single beat: measure latency from the accepting edge.
      @(posedge clk); #1;
      a = W'(16'h1234); b = W'(16'h0FED); cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) q.push_back(model(a, b, cin, sub));
      else chk(nm("first_accept"), 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        lat++;
        if (out_valid) break;
      end
      chk(nm("latency"), 64'(lat), 64'(2 + P));
      @(posedge clk); #1;

      send('1, '0, 1'b1, 1'b0);
      send(W'(5), W'(7), 1'b0, 1'b1);
      send({1'b0, {(W-1){1'b1}}}, '1, 1'b0, 1'b1);
      send(W'(16'hABCD), W'(16'hABCD), 1'b0, 1'b1);
      drain();

      // Backpressure: out_ready low on cycles 3..5 of an 8-beat stream.
      idx = 0; fresh = 1'b1; held = '0;
      for (int cyc = 0; cyc < 40 && (idx < 8 || q.size() != 0); cyc++) begin
        out_ready = !(cyc >= 3 && cyc <= 5);
        in_valid  = (idx < 8);
        if (fresh) begin
          a = rv(); b = rv(); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        if (cyc >= 3 && cyc <= 5) begin
          chk(nm("bp_in_ready_low"), 64'(in_ready), 64'd0);
          chk(nm("bp_out_valid"), 64'(out_valid), 64'd1);
          if (cyc == 3) held = sum;
          else chk(nm("bp_sum_held"), 64'(sum), 64'(held));
        end
        fresh = in_valid && in_ready;
        if (fresh) begin
          q.push_back(model(a, b, cin, sub));
          idx++;
        end
        @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      drain();
      chk(nm("bp_beats_accepted"), 64'(idx), 64'd8);

      // Reset with beats in flight; a beat offered during reset must be dropped.
      send(rv(), rv(), 1'b1, 1'b0);
      send(rv(), rv(), 1'b0, 1'b1);
      send(rv(), rv(), 1'b1, 1'b1);
      rst = 1'b1; in_valid = 1'b1; a = rv(); b = rv();
      @(negedge clk);
      chk(nm("mid_rst_in_ready"), 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      q.delete();
      @(negedge clk);
      chk(nm("mid_rst_out_valid"), 64'(out_valid), 64'd0);
      chk(nm("mid_rst_sum"), 64'(sum), 64'd0);
      for (int k = 0; k < 10; k++) tick();

      // Random traffic with random downstream readiness.
      rnd = 1'b1;
      for (int n = 0; n < 2500; n++) begin
        if ($urandom_range(0, 4) == 0) tick();
        send(rv(), rv(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      rnd = 1'b0; out_ready = 1'b1;
      drain();
      mark_done();
    end
  end

  initial begin
    for (int i = 0; i < 60000 && n_done < NCFG; i++) @(posedge clk);
    if (n_done < NCFG) chk("global_timeout", 64'(n_done), 64'(NCFG));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups with a second-level lookahead carry unit. It replaces the fixed 4-bit registered CLA in arithmetic datapaths that need wider operands, subtraction and backpressure. Operands enter through a valid/ready handshake and leave as registered sum, carry-out, group generate/propagate and optional overflow.

## Interface
- WIDTH, 16: operand width in bits. Must be a multiple of 4, range 4..64. Other values are rejected by an elaboration-time check.
- PIPE, 0: 0 or 1. Setting 1 inserts a register between the group P/G stage and the carry/sum stage.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in. Ignored when sub=1.
- sub  in  1  0 selects A+B+cin. 1 selects A−B, computed as A+~B+1.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of the MSB. When sub=1 this is the not-borrow flag.
- g_out  out  1  whole-word group generate of A and B' (B' = sub ? ~b : b).
- p_out  out  1  whole-word group propagate of A and B'.
- ovf  out  1  signed overflow (see Configuration).

## Operation
- **Stage 0 (input register):** captures a, b, cin and sub when in_valid && in_ready.
  - b is registered as b' = sub ? ~b : b.
  - The effective carry-in is c0 = sub | cin.
- **Stage 1 (group P/G):**
  - Per bit: g = a&b', p = a^b', t = a|b'.
  - Per group k (bits 4k..4k+3): Gk = g3|t3g2|t3t2g1|t3t2t1g0 and Pk = t3t2t1t0.
  - Group lookahead uses t. The sum XOR uses p.
- **Stage 2 (carry/sum, output register):**
  - Second-level lookahead gives the group carry-ins: C(k+1) = Gk | Pk·Ck, with C0 = c0.
  - In-group carries are resolved by 4-bit lookahead. sum[i] = p[i]^c[i].
  - cout = C(WIDTH/4).
  - g_out and p_out are the lookahead combination of all groups, independent of c0.
  - This stage is a flattened two-level tree, not a ripple across groups.
- **Handshake:**
  - A beat transfers on the input when in_valid && in_ready.
  - A beat transfers on the output when out_valid && out_ready.
  - The whole pipeline advances as one unit. stall = out_valid && !out_ready, and in_ready = !stall.
  - While stalled, all stage registers and outputs hold. Results are never dropped or duplicated.
  - Bubbles (valid=0) propagate and may be overwritten. A bubble does not stall upstream.
- **Arithmetic:**
  - All results are modulo 2^WIDTH.
  - cout is the true carry of the WIDTH-bit unsigned add of a, b' and c0.
  - sub=1 with a==b gives sum=0 and cout=1.

## Timing
- Latency from input handshake to out_valid is 2+PIPE cycles when out_ready is held high.
- Throughput is one beat per cycle with no stall.
- While rst is asserted on a clock edge, the next state is:
  - every valid bit = 0, so out_valid = 0;
  - sum = 0, cout = 0, g_out = 0, p_out = 0, ovf = 0;
  - in_ready = 1 during and after reset.
- Reset in the middle of an operation discards all in-flight beats. No partial result is ever presented.
- A beat offered in the same cycle that rst is asserted is not accepted.
- Simultaneous input and output handshakes in one cycle are legal and sustain full rate.
- out_valid may fall only after a completed output handshake, or on reset.

## Configuration
- Macro: CLA_PIPE_OVF_EN.
- **Defined:**
  - ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), which is the signed two's-complement overflow of the effective add.
  - ovf is registered alongside sum and obeys the same stall and reset rules.
- **Undefined:** ovf is tied to 0 and no MSB sign registers are instantiated.

## Test plan
- **Reset then single add:** WIDTH=16, PIPE=0, out_ready=1.
  - Stimulus: a=0x1234, b=0x0FED, cin=1, sub=0.
  - Required: sum=0x2222 and cout=0, with out_valid exactly 2 cycles after acceptance.
- **Full carry chain:** a=0xFFFF, b=0x0000, cin=1.
  - Required: sum=0x0000, cout=1, p_out=1, g_out=0.
- **Subtract:** a=0x0005, b=0x0007, sub=1.
  - Required: sum=0xFFFE and cout=0.
  - With CLA_PIPE_OVF_EN: a=0x7FFF, b=0xFFFF, sub=1 gives sum=0x8000 and ovf=1.
- **Backpressure:** stream 8 beats with out_ready low on cycles 3–5.
  - Required: in_ready low on those same cycles and outputs held.
  - All 8 results arrive in order with none lost or duplicated.
- **Reset mid-stream:** with PIPE=1 and 3 beats in flight, assert rst for 1 cycle.
  - Required: the next cycle shows out_valid=0 and sum=0, and none of the 3 beats ever appears.
- **Random regression:** WIDTH ∈ {4, 16, 64} and PIPE ∈ {0, 1}, 10k random beats with random out_ready.
  - Check sum, cout, g_out, p_out and ovf against a behavioural model.
